// File: rtl/ucc_state_ctrl.sv
// UCC region guard FSM: legal entry/exit tracking, CPU reset request and violation counter.
// Optional interrupt support is compiled in with `define UCC_IRQ_EN.
module ucc_state_ctrl #(
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          CNT_W         = 8
) (
  input  logic             clk,
  input  logic             system_reset,
  input  logic [15:0]      pc,
  input  logic             data_wr,
  input  logic             irq,
  input  logic [15:0]      ucc_min,
  input  logic [15:0]      ucc_max,
  input  logic             violation,
  output logic [1:0]       ucc_state,
  output logic             outside_ucc,
  output logic             reset,
  output logic             ucc_entry,
  output logic             ucc_exit,
  output logic [CNT_W-1:0] viol_count
);

  localparam logic [1:0] NOT_UCC = 2'b00;
  localparam logic [1:0] IN_UCC  = 2'b01;
  localparam logic [1:0] IRQ_ST  = 2'b10;
  localparam logic [1:0] RST_ST  = 2'b11;

  // Declaration initialisers give the power-up state (same as reset, counter cleared).
  logic [1:0]       state_q  = RST_ST;
  logic [15:0]      prev_pc  = 16'h0000;
  logic             reset_q  = 1'b1;
  logic             entry_q  = 1'b0;
  logic             exit_q   = 1'b0;
  logic [CNT_W-1:0] cnt_q    = '0;

  logic [1:0] state_d;
  logic       entry_d;
  logic       exit_d;
  logic       in_region;
  logic       enter_rst;

`ifdef UCC_IRQ_EN
  logic [15:0] resume_pc = 16'h0000;
  logic        irq_take;
`else
  logic        unused_irq;
  assign unused_irq = irq;
`endif

  assign outside_ucc = (pc < ucc_min) | (pc > ucc_max);
  assign in_region   = ~outside_ucc;

  always_comb begin
    state_d = state_q;
    entry_d = 1'b0;
    exit_d  = 1'b0;
`ifdef UCC_IRQ_EN
    irq_take = 1'b0;
`endif
    case (state_q)
      NOT_UCC: begin
        if (in_region) begin
          if (pc == ucc_min) begin
            state_d = IN_UCC;
            entry_d = 1'b1;
          end else begin
            state_d = RST_ST;
          end
        end
      end
      IN_UCC: begin
        // Exit is legal only if the previous instruction was the last one of the region.
        if (outside_ucc) begin
          if (prev_pc == ucc_max) begin
            state_d = NOT_UCC;
            exit_d  = 1'b1;
          end
`ifdef UCC_IRQ_EN
          else if (irq) begin
            state_d  = IRQ_ST;
            irq_take = 1'b1;
          end
`endif
          else begin
            state_d = RST_ST;
          end
        end
      end
      IRQ_ST: begin
`ifdef UCC_IRQ_EN
        if (pc == resume_pc) state_d = IN_UCC;
        else if (in_region)  state_d = RST_ST;
`else
        state_d = RST_ST;
`endif
      end
      default: begin
        if ((pc == RESET_HANDLER) && !data_wr && !system_reset) state_d = NOT_UCC;
      end
    endcase

    // A monitor violation outside RST overrides every other transition.
    if (violation && (state_q != RST_ST)) begin
      state_d = RST_ST;
      entry_d = 1'b0;
      exit_d  = 1'b0;
`ifdef UCC_IRQ_EN
      irq_take = 1'b0;
`endif
    end
  end

  assign enter_rst = (state_q != RST_ST) && (state_d == RST_ST);

  always_ff @(posedge clk) begin
    if (system_reset) begin
      state_q <= RST_ST;
      reset_q <= 1'b1;
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
      prev_pc <= 16'h0000;
`ifdef UCC_IRQ_EN
      resume_pc <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      reset_q <= (state_d == RST_ST);
      entry_q <= entry_d;
      exit_q  <= exit_d;
      prev_pc <= pc;
`ifdef UCC_IRQ_EN
      if (irq_take) resume_pc <= prev_pc;
`endif
      if (enter_rst && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ucc_state  = state_q;
  assign reset      = reset_q;
  assign ucc_entry  = entry_q;
  assign ucc_exit   = exit_q;
  assign viol_count = cnt_q;

endmodule

// File: tb/tb_ucc_state_ctrl.sv
// Directed scoreboard bench for ucc_state_ctrl; the driver queues expected outputs, a monitor checks them.
module tb_ucc_state_ctrl;
  logic        clk = 1'b0;
  logic        system_reset = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic        data_wr = 1'b0;
  logic        irq = 1'b0;
  logic [15:0] ucc_min = 16'hE000;
  logic [15:0] ucc_max = 16'hE0FE;
  logic        violation = 1'b0;
  logic [1:0]  ucc_state;
  logic        outside_ucc;
  logic        reset;
  logic        ucc_entry;
  logic        ucc_exit;
  logic [7:0]  viol_count;

  ucc_state_ctrl #(.RESET_HANDLER(16'h0000), .CNT_W(8)) dut (
    .clk(clk), .system_reset(system_reset), .pc(pc), .data_wr(data_wr), .irq(irq),
    .ucc_min(ucc_min), .ucc_max(ucc_max), .violation(violation),
    .ucc_state(ucc_state), .outside_ucc(outside_ucc), .reset(reset),
    .ucc_entry(ucc_entry), .ucc_exit(ucc_exit), .viol_count(viol_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic       rs;
    logic       en;
    logic       ex;
    logic       ou;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t drv_e;
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_cnt = 8'd0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s got=%0h want=%0h", nm, fld, act, expv);
    end
  endtask

  // Inputs change on the falling edge; the expected outputs apply after the next rising edge.
  task automatic cyc(input string nm, input bit sr, input logic [15:0] p, input bit dw, input bit ir,
                     input bit vi, input bit inc, input logic [1:0] st, input bit rs, input bit en,
                     input bit ex, input bit ou);
    @(negedge clk);
    system_reset = sr; pc = p; data_wr = dw; irq = ir; violation = vi;
    if (inc) exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
    drv_e.name = nm; drv_e.st = st; drv_e.rs = rs; drv_e.en = en; drv_e.ex = ex;
    drv_e.ou = ou; drv_e.cnt = exp_cnt;
    q.push_back(drv_e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk(mon_e.name, "state",   {30'd0, ucc_state}, {30'd0, mon_e.st});
      chk(mon_e.name, "reset",   {31'd0, reset},     {31'd0, mon_e.rs});
      chk(mon_e.name, "entry",   {31'd0, ucc_entry}, {31'd0, mon_e.en});
      chk(mon_e.name, "exit",    {31'd0, ucc_exit},  {31'd0, mon_e.ex});
      chk(mon_e.name, "outside", {31'd0, outside_ucc}, {31'd0, mon_e.ou});
      chk(mon_e.name, "count",   {24'd0, viol_count}, {24'd0, mon_e.cnt});
    end
  end

  initial begin
    //  name            sr  pc        dw ir vi inc st    rs en ex ou
    cyc("por_rst",      1, 16'h0000, 0, 0, 0, 0, 2'b11, 1, 0, 0, 1);
    cyc("rst_recover",  0, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    cyc("idle",         0, 16'hC000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    cyc("entry",        0, 16'hE000, 0, 0, 0, 0, 2'b01, 0, 1, 0, 0);
    cyc("in_mid",       0, 16'hE010, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    cyc("in_max",       0, 16'hE0FE, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    cyc("exit",         0, 16'hC002, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1);
    cyc("post_exit",    0, 16'hC004, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    cyc("bad_entry",    0, 16'hE010, 0, 0, 0, 1, 2'b11, 1, 0, 0, 0);
    cyc("rst_hold_dw",  0, 16'h0000, 1, 0, 0, 0, 2'b11, 1, 0, 0, 1);
    cyc("rst_hold_pc",  0, 16'h0004, 0, 0, 0, 0, 2'b11, 1, 0, 0, 1);
    cyc("rst_leave",    0, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    cyc("above_max",    0, 16'hE0FF, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    cyc("entry_at_max", 0, 16'hE0FE, 0, 0, 0, 1, 2'b11, 1, 0, 0, 0);
    cyc("rst_leave2",   0, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    cyc("entry2",       0, 16'hE000, 0, 0, 0, 0, 2'b01, 0, 1, 0, 0);
    cyc("in_e020",      0, 16'hE020, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
`ifdef UCC_IRQ_EN
    cyc("irq_take",     0, 16'hF800, 0, 1, 0, 0, 2'b10, 0, 0, 0, 1);
    cyc("irq_wait",     0, 16'hF802, 0, 0, 0, 0, 2'b10, 0, 0, 0, 1);
    cyc("irq_resume",   0, 16'hE020, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    cyc("irq_badexit",  0, 16'hC000, 0, 0, 0, 1, 2'b11, 1, 0, 0, 1);
    cyc("irq_leave",    0, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    cyc("irq_entry",    0, 16'hE000, 0, 0, 0, 0, 2'b01, 0, 1, 0, 0);
    cyc("irq_e020",     0, 16'hE020, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    cyc("irq_take2",    0, 16'hF800, 0, 1, 0, 0, 2'b10, 0, 0, 0, 1);
    cyc("irq_wrongpc",  0, 16'hE030, 0, 0, 0, 1, 2'b11, 1, 0, 0, 0);
    cyc("irq_leave2",   0, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    cyc("irq_entry3",   0, 16'hE000, 0, 0, 0, 0, 2'b01, 0, 1, 0, 0);
    cyc("irq_e020b",    0, 16'hE020, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    cyc("irq_take3",    0, 16'hF800, 0, 1, 0, 0, 2'b10, 0, 0, 0, 1);
    cyc("irq_sysrst",   1, 16'h0000, 0, 0, 0, 0, 2'b11, 1, 0, 0, 1);
`else
    cyc("irq_disabled", 0, 16'hF800, 0, 1, 0, 1, 2'b11, 1, 0, 0, 1);
`endif
    cyc("rst_leave3",   0, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    cyc("entry4",       0, 16'hE000, 0, 0, 0, 0, 2'b01, 0, 1, 0, 0);
    cyc("viol_in",      0, 16'hE002, 0, 0, 1, 1, 2'b11, 1, 0, 0, 0);
    cyc("viol_in_rst",  0, 16'h0000, 0, 0, 1, 0, 2'b00, 0, 0, 0, 1);
    cyc("sr_viol",      1, 16'h0000, 0, 0, 1, 0, 2'b11, 1, 0, 0, 1);
    cyc("sr_release",   0, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    for (int i = 0; i < 260; i++) begin
      cyc("sat_viol",   0, 16'h0000, 0, 0, 1, 1, 2'b11, 1, 0, 0, 1);
      cyc("sat_leave",  0, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    end
    cyc("sat_hold",     0, 16'h0000, 0, 0, 1, 1, 2'b11, 1, 0, 0, 1);
    cyc("sr_keep_cnt",  1, 16'h0000, 0, 0, 0, 0, 2'b11, 1, 0, 0, 1);
    cyc("final",        0, 16'h0000, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    checks++;
    if (viol_count !== 8'hFF) begin
      errors++;
      $display("FAIL saturation got=%0h want=ff", viol_count);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
